bin_to_bcd_seq: RTL
===================

# bin_to_bcd_seq

Sequential binary-to-BCD converter using shift-and-add-3 (double dabble), one bit per clock. Accepts an unsigned binary word on a start strobe and returns packed BCD digits with a one-cycle done pulse. Sits directly upstream of the BCD-to-Excess-3 code converter: each 4-bit digit of `bcd` feeds one converter instance, so every digit is always in the range 0..9.

## Interface
- `WIDTH`, default 8: binary input width, ≥ 1.
- `DIGITS`, default 3: number of BCD digits produced, ≥ 1.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `start`  in  1: request a conversion of `bin`; sampled only in IDLE.
- `bin`  in  WIDTH: unsigned binary operand; sampled on the accepting edge only.
- `busy`  out  1: high while a conversion is in progress.
- `done`  out  1: one-cycle pulse; `bcd` is valid and updated in the same cycle.
- `bcd`  out  4*DIGITS: packed result; digit k occupies bits [4k+3:4k], k=0 is least significant.
- `ovf`  out  1: present only with `BIN2BCD_OVF_EN`; result exceeded DIGITS digits.

## Operation
- Internal state: working register of 4*DIGITS BCD bits plus WIDTH binary bits, and a bit counter of ceil(log2(WIDTH+1)) bits.
- FSM states IDLE and SHIFT.
- In IDLE with `start`=1: the binary field loads `bin`, the BCD field clears to 0, the counter loads WIDTH, and the FSM moves to SHIFT.
- In SHIFT, on every edge:
  - Add 3 to each BCD digit whose value is ≥ 5, based on the pre-shift value, with all digits corrected in parallel.
  - Shift the combined register left by 1. The binary MSB enters BCD bit 0, and the top BCD bit is shifted out.
  - Decrement the counter.
- On the edge where the counter goes from 1 to 0:
  - The post-shift BCD field is written to the `bcd` output register.
  - `done` is set for one cycle and the FSM returns to IDLE.
- `start` while in SHIFT is ignored. It is not queued.
- `bcd` holds the last completed result until the next completion. Outputs do not change while busy.
- If DIGITS is too small for the value, `bcd` equals `bin` mod 10^DIGITS. Bits shifted out of the top digit are discarded.
- Every digit of a completed `bcd` is 0..9 for all inputs.

## Timing
- Reset values: FSM=IDLE, `busy`=0, `done`=0, `bcd`=0, `ovf`=0, working register and counter cleared.
- Latency:
  - Let `start` be accepted on edge T0.
  - `busy`=1 from after T0 through edge T(WIDTH).
  - `done`=1 and new `bcd` appear after edge T(WIDTH) and last one cycle.
  - `busy`=0 in the `done` cycle.
- Throughput:
  - `start` may be held high during the `done` cycle. It is accepted on edge T(WIDTH+1).
  - The back-to-back period is WIDTH+1 cycles.
- Reset asserted mid-conversion: the conversion aborts immediately, all outputs take their reset values, and no `done` is issued.
- `bin` may change freely after the accepting edge.

## Configuration
- `BIN2BCD_OVF_EN` defined:
  - The `ovf` port exists.
  - The sticky overflow bit clears on start acceptance and sets if any 1 is shifted out of the top BCD digit.
  - `ovf` is registered together with `bcd` on the completion edge and holds until the next completion.
  - Reset value is 0.
- `BIN2BCD_OVF_EN` undefined:
  - No `ovf` port and no overflow logic.
  - Truncation behaviour is unchanged.

## Test plan
- Reset, then `bin`=0, WIDTH=8, DIGITS=3 -> `done` pulses 8 cycles after the accepting edge with `bcd`=12'h000; `busy` is high for exactly 8 cycles.
- Sweep `bin`=0..255 back-to-back, holding `start` high -> each result matches the decimal value (e.g. 99->12'h099, 128->12'h128, 255->12'h255); `done` arrives every 9 cycles; no digit exceeds 9.
- `start` pulsed again with `bin`=7 three cycles into a conversion of 200 -> the second `start` is ignored; the single `done` gives `bcd`=12'h200.
- `rst` asserted 4 cycles into a conversion of 255 -> outputs go to 0 immediately; no `done`; the next conversion of 42 returns 12'h042.
- WIDTH=8, DIGITS=2 with `BIN2BCD_OVF_EN` defined, `bin`=200 -> `bcd`=8'h00 and `ovf`=1. A following conversion of 99 -> `bcd`=8'h99 and `ovf`=0.
- WIDTH=16, DIGITS=5, `bin`=65535 -> `bcd`=20'h65535 after 16 cycles.

Source files
------------

// File: rtl/bin_to_bcd_seq_if.sv
// Handshake/result bundle for the sequential binary-to-BCD converter.
// The ovf signal exists only when BIN2BCD_OVF_EN is defined.
interface bin_to_bcd_seq_if #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
);
  logic                  start;
  logic [WIDTH-1:0]      bin;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;
`ifdef BIN2BCD_OVF_EN
  logic                  ovf;
`endif

  // Requester side: issues operands, observes results
  modport master (
    output start, bin,
`ifdef BIN2BCD_OVF_EN
    input  ovf,
`endif
    input  busy, done, bcd
  );

  // Converter side
  modport slave (
    input  start, bin,
`ifdef BIN2BCD_OVF_EN
    output ovf,
`endif
    output busy, done, bcd
  );
endinterface

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock).
// Optional feature macro: BIN2BCD_OVF_EN adds a sticky overflow flag (ovf)
// reporting that a 1 was shifted out of the top BCD digit.
module bin_to_bcd_seq #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic clk,
  input  logic rst,
  bin_to_bcd_seq_if.slave bus
);
  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_nxt;
  logic [BW-1:0]    bcd_work, bcd_corr, bcd_q;
  logic [WIDTH-1:0] bin_work;
  logic [CW-1:0]    cnt;
  logic             done_q;
  logic             accept, last;

  assign accept = (state == IDLE) && bus.start;
  assign last   = (state == SHIFT) && (cnt == CW'(1));

  // Add-3 correction on every digit >= 5, all digits in parallel, pre-shift
  always_comb begin
    bcd_corr = bcd_work;
    for (int k = 0; k < DIGITS; k++) begin
      if (bcd_work[4*k +: 4] >= 4'd5)
        bcd_corr[4*k +: 4] = bcd_work[4*k +: 4] + 4'd3;
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic: start ignored while shifting, return to IDLE on last bit
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = SHIFT;
      SHIFT:   if (cnt == CW'(1)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Working register, bit counter and result register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcd_work <= '0;
      bin_work <= '0;
      cnt      <= '0;
      bcd_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= last;
      if (accept) begin
        bcd_work <= '0;
        bin_work <= bus.bin;
        cnt      <= CW'(WIDTH);
      end else if (state == SHIFT) begin
        // Top corrected BCD bit falls off; binary MSB enters BCD bit 0
        bcd_work <= {bcd_corr[BW-2:0], bin_work[WIDTH-1]};
        bin_work <= bin_work << 1;
        cnt      <= cnt - CW'(1);
        if (last) bcd_q <= {bcd_corr[BW-2:0], bin_work[WIDTH-1]};
      end
    end
  end

`ifdef BIN2BCD_OVF_EN
  logic ovf_work, ovf_q;

  // Sticky overflow: cleared on accept, set by any 1 leaving the top digit;
  // published alongside bcd on the completion edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_work <= 1'b0;
      ovf_q    <= 1'b0;
    end else if (accept) begin
      ovf_work <= 1'b0;
    end else if (state == SHIFT) begin
      ovf_work <= ovf_work | bcd_corr[BW-1];
      if (last) ovf_q <= ovf_work | bcd_corr[BW-1];
    end
  end

  assign bus.ovf = ovf_q;
`else
  // Without overflow reporting the bit shifted out is simply discarded
  logic unused_top;
  assign unused_top = bcd_corr[BW-1];
`endif

  assign bus.busy = (state == SHIFT);
  assign bus.done = done_q;
  assign bus.bcd  = bcd_q;
endmodule
